// File: rtl/lab7soc_pio_ctrl.sv
// -----------------------------------------------------------------------------
// lab7soc_pio_ctrl
//   Avalon-MM parallel I/O slave for lab7soc. It provides:
//   - a WIDTH-bit output register with atomic set and clear
//   - a synchronised input port with rising-edge capture
//   - a maskable level interrupt
//   - an optional hardware timed pulse, enabled by defining PIO_PULSE_EN.
//     Software can use it to hold a line (e.g. USB reset) high for an exact
//     number of cycles.
//
// Register map (word address):
//   0 DATA      R/W  output register
//   1 IN        R    synchronised input (in_s2)
//   2 IRQ_MASK  R/W  interrupt enable per bit
//   3 EDGE_CAP  R/W1C captured rising edges
//   4 OUTSET    W    OR writedata into DATA, reads 0
//   5 OUTCLR    W    clear DATA bits where writedata is 1, reads 0
//   6 PULSE     R/W  with PIO_PULSE_EN: pulse start / remaining count;
//                    otherwise reserved
//   7 reserved  reads 0, writes ignored
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   address    word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data (bits above WIDTH ignored)
//   readdata   read data, zero-extended, combinational from address
//   in_port    asynchronous external inputs
//   out_port   registered outputs
//   irq        level interrupt, |(EDGE_CAP & IRQ_MASK)
//
// Bus handshake: there is no valid/ready pair. A write is accepted on every
// rising edge where chipselect=1 and write_n=0. readdata always reflects
// the addressed register in the same cycle (zero wait states, read
// latency 0).
// -----------------------------------------------------------------------------
module lab7soc_pio_ctrl #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int unsigned      PULSE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_IN     = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;
  localparam logic [2:0] ADDR_PULSE  = 3'd6;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             unused_wdata;

  logic [WIDTH-1:0] data_out, data_nxt;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap, edge_nxt, edge_clr;
  logic [WIDTH-1:0] in_s1, in_s2, in_s3;

  // Interface to the optional pulse engine.
  logic             pulse_load;   // accepted nonzero PULSE write this cycle
  logic [WIDTH-1:0] expire_clr;   // bits to drop as the counter reaches 0
  logic [31:0]      pulse_rdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // ---------------------------------------------------------------------------
  // Pulse engine
  // ---------------------------------------------------------------------------
`ifdef PIO_PULSE_EN
  localparam int unsigned CW = $clog2(PULSE_CYCLES + 1);

  logic [CW-1:0]    pulse_cnt;
  logic [WIDTH-1:0] pulse_mask;
  logic             pulse_expire;

  assign pulse_load = wr_en && (address == ADDR_PULSE) && (wdata != '0);
  // A reload on the last count restarts the pulse instead of ending it, so
  // the 1->0 transition never happens in that cycle.
  assign pulse_expire = (pulse_cnt == CW'(1)) && !pulse_load;
  assign expire_clr   = pulse_expire ? pulse_mask : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_cnt  <= '0;
      pulse_mask <= '0;
    end else if (pulse_load) begin
      pulse_cnt  <= CW'(PULSE_CYCLES);
      pulse_mask <= pulse_mask | wdata;
    end else begin
      if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - CW'(1);
      if (pulse_expire) pulse_mask <= '0;
    end
  end

  always_comb begin
    pulse_rdata         = '0;
    pulse_rdata[CW-1:0] = pulse_cnt;
  end
`else
  logic unused_pulse_cfg;

  assign pulse_load       = 1'b0;
  assign expire_clr       = '0;
  assign pulse_rdata      = '0;
  assign unused_pulse_cfg = (PULSE_CYCLES != 0);
`endif

  // ---------------------------------------------------------------------------
  // Output register: the expiry clear is applied first, then any write on
  // top of it, so a write in the expiry cycle wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_nxt = data_out & ~expire_clr;
    if (wr_en) begin
      case (address)
        ADDR_DATA:   data_nxt = wdata;
        ADDR_OUTSET: data_nxt = data_nxt | wdata;
        ADDR_OUTCLR: data_nxt = data_nxt & ~wdata;
        ADDR_PULSE:  if (pulse_load) data_nxt = data_nxt | wdata;
        default:     ;
      endcase
    end
  end

  // A new edge in the same cycle as a clear keeps its bit set.
  assign edge_clr = (wr_en && (address == ADDR_EDGE)) ? wdata : '0;
  assign edge_nxt = (edge_cap & ~edge_clr) | (in_s2 & ~in_s3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
      irq_mask <= '0;
      edge_cap <= '0;
      in_s1    <= '0;
      in_s2    <= '0;
      in_s3    <= '0;
    end else begin
      data_out <= data_nxt;
      edge_cap <= edge_nxt;
      in_s1    <= in_port;
      in_s2    <= in_s1;
      in_s3    <= in_s2;
      if (wr_en && (address == ADDR_MASK)) irq_mask <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:  readdata[WIDTH-1:0] = data_out;
      ADDR_IN:    readdata[WIDTH-1:0] = in_s2;
      ADDR_MASK:  readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE:  readdata[WIDTH-1:0] = edge_cap;
      ADDR_PULSE: readdata            = pulse_rdata;
      default:    readdata            = '0;
    endcase
  end

  assign out_port = data_out;
  assign irq      = |(edge_cap & irq_mask);

endmodule

// File: doc/lab7soc_pio_ctrl.md
# lab7soc_pio_ctrl

Parametrised Avalon-MM parallel I/O slave for the lab7soc system; successor to the single-bit output PIO used for the USB reset line. Provides a WIDTH-bit output register with atomic set/clear, a synchronised input port with rising-edge capture and a maskable interrupt, and a hardware timed-pulse mode, so software can assert a line (e.g. USB reset) for an exact cycle count without busy-waiting. Sits on the Nios II data master's Avalon fabric and drives board pins or peripheral reset/control lines.

## Interface
- WIDTH, 8, output/input port width, 1..32
- RESET_VALUE, 0, value of out_port after reset (WIDTH bits)
- PULSE_CYCLES, 1000, pulse length in clk cycles, >= 1
- clk  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word address of register
- chipselect  in  1  Avalon slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above WIDTH ignored
- readdata  out  32  read data, zero-extended
- in_port  in  WIDTH  asynchronous external inputs
- out_port  out  WIDTH  registered outputs
- irq  out  1  level interrupt, active-high

## Operation
- Write = chipselect & ~write_n; one access per cycle; zero wait states.
- 0 DATA: W loads data_out; R returns data_out.
- 1 IN: R returns synchronised input (in_s2); W ignored.
- 2 IRQ_MASK: R/W, WIDTH bits.
- 3 EDGE_CAP: R returns captured rising edges; W-1-to-clear per bit.
- 4 OUTSET: W ORs writedata into data_out; R returns 0.
- 5 OUTCLR: W clears data_out bits where writedata is 1; R returns 0.
- 6 PULSE: W with nonzero data sets those bits in data_out, ORs them into pulse_mask, (re)loads counter with PULSE_CYCLES; W of 0 ignored. R returns remaining count.
- 7: reserved, reads 0, writes ignored.
- Input path: in_port -> in_s1 -> in_s2 -> in_s3; edge = in_s2 & ~in_s3; edge sets EDGE_CAP bit.
- irq = |(EDGE_CAP & IRQ_MASK), combinational from registers.
- Pulse counter: width $clog2(PULSE_CYCLES+1); decrements when nonzero; on the 1->0 transition data_out &= ~pulse_mask and pulse_mask cleared.
- Collisions: EDGE_CAP clear and new edge same bit same cycle -> bit stays set. Pulse expiry and register write same cycle -> expiry clear applied first, write applied on top (write wins). DATA/OUTCLR writes do not stop the counter; expiry still clears pulse_mask bits.
- Reset (any time, incl. mid-pulse): data_out = RESET_VALUE, IRQ_MASK = 0, EDGE_CAP = 0, sync flops = 0, counter = 0, pulse_mask = 0; irq = 0.

## Timing
- readdata combinational from address; read latency 0.
- Register writes visible on out_port one edge after the write cycle.
- PULSE written at edge T: bits high from T+1, cleared at edge T+PULSE_CYCLES (exactly PULSE_CYCLES cycles high if previously low).
- Re-write of PULSE while active restarts full PULSE_CYCLES count from the new write.
- in_port rising, stable before edge E0: IN reads 1 after E1; EDGE_CAP bit set and irq high after E2.

## Configuration
- PIO_PULSE_EN defined: PULSE register, counter and pulse_mask present as above.
- PIO_PULSE_EN undefined: no counter logic; address 6 behaves as reserved (reads 0, writes ignored); PULSE_CYCLES unused.

## Test plan
- Reset with WIDTH=8, RESET_VALUE=8'hA5 -> out_port=8'hA5, irq=0, all reads of 2/3/6 return 0.
- Write DATA=8'h0F, OUTSET=8'hF0, OUTCLR=8'h81 -> out_port 8'h0F, 8'hFF, 8'h7E on successive edges; readback matches.
- IRQ_MASK=8'h04, in_port[2] 0->1 -> EDGE_CAP=8'h04 and irq=1 two edges after sync; write EDGE_CAP=8'h04 -> irq=0; clear coinciding with new edge -> bit stays 1.
- PULSE_CYCLES=10, write PULSE=8'h01 -> out_port[0] high exactly 10 cycles, PULSE reads 10..1 then 0; rewrite at count 3 -> high 10 more cycles.
- Expiry cycle coincides with OUTSET=8'h01 -> out_port[0] remains 1; reset_n asserted mid-pulse -> out_port=RESET_VALUE, counter 0 immediately.
- Build without PIO_PULSE_EN: write address 6 = 8'hFF -> out_port unchanged, read returns 0.
